// File: rtl/board_engine_pkg.sv
// Shared definitions for the falling-block board engine.
// Contents:
//   - state_e     : engine FSM state encoding
//   - *_BLOCK     : piece codes accepted on next_piece
//   - CMD_*       : command codes accepted on cmd
//   - spawn_col() : spawn anchor column for a given board width
//   - sat_inc16() : saturating 16-bit increment
package board_engine_pkg;

  typedef enum logic [2:0] {
    ST_SPAWN = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DROP  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_SCAN  = 3'd4,
    ST_SHIFT = 3'd5,
    ST_OVER  = 3'd6
  } state_e;

  localparam logic [3:0] O_BLOCK = 4'd0;
  localparam logic [3:0] I_BLOCK = 4'd1;
  localparam logic [3:0] S_BLOCK = 4'd2;
  localparam logic [3:0] Z_BLOCK = 4'd3;
  localparam logic [3:0] L_BLOCK = 4'd4;
  localparam logic [3:0] J_BLOCK = 4'd5;
  localparam logic [3:0] T_BLOCK = 4'd6;

  localparam logic [2:0] CMD_LEFT  = 3'd0;
  localparam logic [2:0] CMD_RIGHT = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_CW    = 3'd3;
  localparam logic [2:0] CMD_CCW   = 3'd4;
  localparam logic [2:0] CMD_DROP  = 3'd5;

  // New pieces appear with their 4x4 box just left of the board centre.
  function automatic int spawn_col(input int width);
    return width / 2 - 1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/piece_shape.sv
// Shape table: (piece, angle) -> four cell offsets inside a 4x4 box.
// Ports:
//   piece [3:0] : piece code (unknown codes fall back to the O shape)
//   angle [1:0] : rotation, 0..3 clockwise quarter turns
//   dx    [7:0] : cell i column offset in dx[2i+1:2i]
//   dy    [7:0] : cell i row offset in dy[2i+1:2i]
module piece_shape
  import board_engine_pkg::*;
(
  input  logic [3:0] piece,
  input  logic [1:0] angle,
  output logic [7:0] dx,
  output logic [7:0] dy
);

  // Each hex digit is one cell encoded as 4*dy + dx; cell 0 is the low digit.
  logic [15:0] cells;

  // Shape lookup.
  always_comb begin
    cells = 16'h5410;
    case (piece)
      I_BLOCK: case (angle)
        2'd0:    cells = 16'h7654;
        2'd1:    cells = 16'hEA62;
        2'd2:    cells = 16'hBA98;
        default: cells = 16'hD951;
      endcase
      S_BLOCK: case (angle)
        2'd0:    cells = 16'h5421;
        2'd1:    cells = 16'hA651;
        2'd2:    cells = 16'h9865;
        default: cells = 16'h9540;
      endcase
      Z_BLOCK: case (angle)
        2'd0:    cells = 16'h6510;
        2'd1:    cells = 16'h9652;
        2'd2:    cells = 16'hA954;
        default: cells = 16'h8541;
      endcase
      L_BLOCK: case (angle)
        2'd0:    cells = 16'h6542;
        2'd1:    cells = 16'hA951;
        2'd2:    cells = 16'h8654;
        default: cells = 16'h9510;
      endcase
      J_BLOCK: case (angle)
        2'd0:    cells = 16'h6540;
        2'd1:    cells = 16'h9521;
        2'd2:    cells = 16'hA654;
        default: cells = 16'h9851;
      endcase
      T_BLOCK: case (angle)
        2'd0:    cells = 16'h6541;
        2'd1:    cells = 16'h9651;
        2'd2:    cells = 16'h9654;
        default: cells = 16'h9541;
      endcase
      default: cells = 16'h5410;
    endcase
  end

  // Split the packed nibbles into separate dx/dy vectors.
  always_comb begin
    dx = 8'd0;
    dy = 8'd0;
    for (int i = 0; i < 4; i++) begin
      dx[2*i +: 2] = cells[4*i +: 2];
      dy[2*i +: 2] = cells[4*i+2 +: 2];
    end
  end

endmodule

// File: rtl/board_engine.sv
// Falling-block game board engine.
// The fixed stack is a HEIGHT x WIDTH bit array; the active piece is held
// only as code/angle/anchor and merged into the array when it locks.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   tick                : gravity pulse
//   cmd_valid/cmd       : command request (left/right/down/cw/ccw/hard-drop)
//   cmd_ready           : commands accepted (PLAY only)
//   cmd_done/cmd_ok     : one-cycle resolution pulse and result
//   next_piece          : piece code loaded at spawn
//   rd_x/rd_y           : display read address
//   rd_cell/rd_active   : combinational occupancy at the read address
//   lines_cleared       : saturating count of removed rows
//   game_over           : sticky until reset
module board_engine
  import board_engine_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      cmd_valid,
  input  logic [2:0]                cmd,
  output logic                      cmd_ready,
  output logic                      cmd_done,
  output logic                      cmd_ok,
  input  logic [3:0]                next_piece,
  input  logic [$clog2(WIDTH)-1:0]  rd_x,
  input  logic [$clog2(HEIGHT)-1:0] rd_y,
  output logic                      rd_cell,
  output logic                      rd_active,
  output logic [15:0]               lines_cleared,
  output logic                      game_over
);

  localparam int XI = $clog2(WIDTH);
  localparam int YI = $clog2(HEIGHT);
  // Two extra bits give a sign bit plus headroom for anchor + offset.
  localparam int XW = XI + 2;
  localparam int YW = YI + 2;
  localparam logic [XW-1:0] SPAWN_X = XW'(spawn_col(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] board_q [HEIGHT];
  logic [WIDTH-1:0] board_d [HEIGHT];
  logic [3:0]       piece_q, piece_d;
  logic [1:0]       angle_q, angle_d;
  logic [XW-1:0]    ax_q, ax_d;
  logic [YW-1:0]    ay_q, ay_d;
  logic [YI-1:0]    row_q, row_d;
  logic             tick_pend_q, tick_pend_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_done_q, cmd_done_d;
  logic             cmd_ok_q, cmd_ok_d;
  logic             game_over_q, game_over_d;
  logic [15:0]      lines_q, lines_d;

  logic [3:0]       cand_piece;
  logic [1:0]       cand_angle;
  logic [XW-1:0]    cand_ax;
  logic [YW-1:0]    cand_ay;
  logic [7:0]       cand_dx, cand_dy, cur_dx, cur_dy;
  logic [XW-1:0]    cand_x [4];
  logic [YW-1:0]    cand_y [4];
  logic             cand_legal;
  logic [XW-1:0]    cur_x [4];
  logic [YW-1:0]    cur_y [4];
  logic [3:0]       cur_in;
  logic             accept;
  logic             rd_in, live;

  assign accept = cmd_ready_q && cmd_valid;

  piece_shape u_cur_shape (
    .piece (piece_q),
    .angle (angle_q),
    .dx    (cur_dx),
    .dy    (cur_dy)
  );

  piece_shape u_cand_shape (
    .piece (cand_piece),
    .angle (cand_angle),
    .dx    (cand_dx),
    .dy    (cand_dy)
  );

  // Candidate placement: spawn position, the requested move, or one row down.
  always_comb begin
    cand_piece = piece_q;
    cand_angle = angle_q;
    cand_ax    = ax_q;
    cand_ay    = ay_q;
    case (state_q)
      ST_SPAWN: begin
        cand_piece = next_piece;
        cand_angle = 2'd0;
        cand_ax    = SPAWN_X;
        cand_ay    = YW'(0);
      end
      ST_PLAY: begin
        if (accept) begin
          case (cmd)
            CMD_LEFT:  cand_ax    = ax_q - XW'(1);
            CMD_RIGHT: cand_ax    = ax_q + XW'(1);
            CMD_DOWN:  cand_ay    = ay_q + YW'(1);
            CMD_CW:    cand_angle = angle_q + 2'd1;
            CMD_CCW:   cand_angle = angle_q - 2'd1;
            default:   cand_ay    = ay_q;
          endcase
        end else begin
          // Gravity (live or pending tick) is the only other move in PLAY.
          cand_ay = ay_q + YW'(1);
        end
      end
      ST_DROP: cand_ay = ay_q + YW'(1);
      default: cand_ay = ay_q;
    endcase
  end

  // Candidate legality: every cell on the board and over an empty fixed cell.
  // The sign bit catches anchors pushed past the left or top wall.
  always_comb begin
    cand_legal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cand_x[i] = cand_ax + XW'(cand_dx[2*i +: 2]);
      cand_y[i] = cand_ay + YW'(cand_dy[2*i +: 2]);
      if (!cand_x[i][XW-1] && (cand_x[i] < XW'(WIDTH)) &&
          !cand_y[i][YW-1] && (cand_y[i] < YW'(HEIGHT))) begin
        if (board_q[cand_y[i][YI-1:0]][cand_x[i][XI-1:0]]) begin
          cand_legal = 1'b0;
        end else begin
        end
      end else begin
        cand_legal = 1'b0;
      end
    end
  end

  // Absolute cells of the current piece, used for display and lock.
  always_comb begin
    cur_in = 4'd0;
    for (int i = 0; i < 4; i++) begin
      cur_x[i]  = ax_q + XW'(cur_dx[2*i +: 2]);
      cur_y[i]  = ay_q + YW'(cur_dy[2*i +: 2]);
      cur_in[i] = !cur_x[i][XW-1] && (cur_x[i] < XW'(WIDTH)) &&
                  !cur_y[i][YW-1] && (cur_y[i] < YW'(HEIGHT));
    end
  end

  // Display port: fixed stack merged with the live piece.
  always_comb begin
    rd_in     = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
    live      = (state_q == ST_PLAY) || (state_q == ST_DROP) || (state_q == ST_LOCK);
    rd_active = 1'b0;
    if (rd_in && live) begin
      for (int i = 0; i < 4; i++) begin
        if ((cur_x[i] == XW'(rd_x)) && (cur_y[i] == YW'(rd_y))) begin
          rd_active = 1'b1;
        end else begin
        end
      end
    end else begin
      rd_active = 1'b0;
    end
    rd_cell = rd_in ? (board_q[rd_y][rd_x] | rd_active) : 1'b0;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    piece_d     = piece_q;
    angle_d     = angle_q;
    ax_d        = ax_q;
    ay_d        = ay_q;
    row_d       = row_q;
    tick_pend_d = tick_pend_q;
    lines_d     = lines_q;
    cmd_done_d  = 1'b0;
    cmd_ok_d    = 1'b0;
    case (state_q)
      ST_SPAWN: begin
        piece_d = next_piece;
        angle_d = 2'd0;
        ax_d    = SPAWN_X;
        ay_d    = YW'(0);
        state_d = cand_legal ? ST_PLAY : ST_OVER;
      end
      ST_PLAY: begin
        if (accept) begin
          // A tick colliding with a command waits for the next PLAY cycle.
          tick_pend_d = tick_pend_q | tick;
          case (cmd)
            CMD_DROP: state_d = ST_DROP;
            CMD_LEFT, CMD_RIGHT, CMD_DOWN, CMD_CW, CMD_CCW: begin
              cmd_done_d = 1'b1;
              if (cand_legal) begin
                ax_d     = cand_ax;
                ay_d     = cand_ay;
                angle_d  = cand_angle;
                cmd_ok_d = 1'b1;
              end else if (cmd == CMD_DOWN) begin
                state_d = ST_LOCK;
              end else begin
                state_d = ST_PLAY;
              end
            end
            default: cmd_done_d = 1'b1;
          endcase
        end else if (tick || tick_pend_q) begin
          tick_pend_d = 1'b0;
          if (cand_legal) begin
            ay_d = cand_ay;
          end else begin
            state_d = ST_LOCK;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_DROP: begin
        if (cand_legal) begin
          ay_d = cand_ay;
        end else begin
          state_d    = ST_LOCK;
          cmd_done_d = 1'b1;
          cmd_ok_d   = 1'b1;
        end
      end
      ST_LOCK: begin
        for (int i = 0; i < 4; i++) begin
          if (cur_in[i]) begin
            board_d[cur_y[i][YI-1:0]][cur_x[i][XI-1:0]] = 1'b1;
          end else begin
          end
        end
        // Any gravity still queued belonged to the piece that just landed.
        tick_pend_d = 1'b0;
        row_d       = YI'(HEIGHT - 1);
        state_d     = ST_SCAN;
      end
      ST_SCAN: begin
        if (&board_q[row_q]) begin
          state_d = ST_SHIFT;
        end else if (row_q == YI'(0)) begin
          state_d = ST_SPAWN;
        end else begin
          row_d = row_q - YI'(1);
        end
      end
      ST_SHIFT: begin
        // Rows above the full row slide down one; rescan the same row.
        for (int r = 1; r < HEIGHT; r++) begin
          if (r <= int'(row_q)) begin
            board_d[r] = board_q[r-1];
          end else begin
          end
        end
        board_d[0] = '0;
        lines_d    = sat_inc16(lines_q);
        state_d    = ST_SCAN;
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_SPAWN;
    endcase
    cmd_ready_d = (state_d == ST_PLAY);
    game_over_d = game_over_q | (state_d == ST_OVER);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_SPAWN;
      for (int r = 0; r < HEIGHT; r++) begin
        board_q[r] <= '0;
      end
      piece_q     <= 4'd0;
      angle_q     <= 2'd0;
      ax_q        <= '0;
      ay_q        <= '0;
      row_q       <= '0;
      tick_pend_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      cmd_ok_q    <= 1'b0;
      game_over_q <= 1'b0;
      lines_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      piece_q     <= piece_d;
      angle_q     <= angle_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      row_q       <= row_d;
      tick_pend_q <= tick_pend_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_done_q  <= cmd_done_d;
      cmd_ok_q    <= cmd_ok_d;
      game_over_q <= game_over_d;
      lines_q     <= lines_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign cmd_done      = cmd_done_q;
  assign cmd_ok        = cmd_ok_q;
  assign game_over     = game_over_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine: reset, wall, line clear, tick/command
// collision, game over and reset during a row shift.
module tb_board_engine;
  import board_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst, tick, cmd_valid;
  logic [2:0]  cmd;
  logic        cmd_ready, cmd_done, cmd_ok;
  logic [3:0]  next_piece;
  logic [3:0]  rd_x;
  logic [4:0]  rd_y;
  logic        rd_cell, rd_active;
  logic [15:0] lines_cleared;
  logic        game_over;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  board_engine #(.WIDTH(10), .HEIGHT(20)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd),
    .cmd_ready     (cmd_ready),
    .cmd_done      (cmd_done),
    .cmd_ok        (cmd_ok),
    .next_piece    (next_piece),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_cell       (rd_cell),
    .rd_active     (rd_active),
    .lines_cleared (lines_cleared),
    .game_over     (game_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y, output logic c, output logic a);
    rd_x = 4'(x);
    rd_y = 5'(y);
    #1;
    c = rd_cell;
    a = rd_active;
  endtask

  task automatic check_cell(input string tag, input int x, input int y,
                            input logic ec, input logic ea);
    logic c, a;
    probe(x, y, c, a);
    check({tag, "_cell"}, 32'(c), 32'(ec));
    check({tag, "_act"},  32'(a), 32'(ea));
  endtask

  task automatic wait_play(input string tag, input int budget);
    int n = 0;
    while (!cmd_ready && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(cmd_ready), 32'd1);
  endtask

  task automatic send(input logic [2:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic move_cmd(input string tag, input logic [2:0] c, input logic exp_ok);
    send(c);
    check({tag, "_done"}, 32'(cmd_done), 32'd1);
    check({tag, "_ok"},   32'(cmd_ok),   32'(exp_ok));
  endtask

  task automatic hard_drop(input string tag);
    int n = 0;
    send(CMD_DROP);
    check({tag, "_early"}, 32'(cmd_done), 32'd0);
    while (!cmd_done && n < 40) begin
      step();
      n++;
    end
    check({tag, "_done"}, 32'(cmd_done), 32'd1);
    check({tag, "_ok"},   32'(cmd_ok),   32'd1);
  endtask

  // Fresh O piece at column 4 -> move to target column and hard-drop.
  task automatic drop_at(input string tag, input int target);
    wait_play({tag, "_play"}, 60);
    for (int k = 0; k < 4 - target; k++) move_cmd({tag, "_l"}, CMD_LEFT, 1'b1);
    for (int k = 0; k < target - 4; k++) move_cmd({tag, "_r"}, CMD_RIGHT, 1'b1);
    hard_drop(tag);
  endtask

  task automatic count_cells(output int fixed, output int act);
    logic c, a;
    fixed = 0;
    act   = 0;
    for (int y = 0; y < 20; y++) begin
      for (int x = 0; x < 10; x++) begin
        probe(x, y, c, a);
        if (c && !a) fixed++;
        if (a) act++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fixed, act, n;
    rst = 1'b0; tick = 1'b0; cmd_valid = 1'b0; cmd = 3'd0;
    next_piece = O_BLOCK; rd_x = 4'd0; rd_y = 5'd0;

    // Reset
    step(); step();
    rst = 1'b1;
    wait_play("reset_play", 2);
    check("reset_lines", 32'(lines_cleared), 32'd0);
    check("reset_over", 32'(game_over), 32'd0);
    check("reset_done", 32'(cmd_done), 32'd0);
    check_cell("spawn_40", 4, 0, 1'b1, 1'b1);
    check_cell("spawn_50", 5, 0, 1'b1, 1'b1);
    check_cell("spawn_41", 4, 1, 1'b1, 1'b1);
    check_cell("spawn_51", 5, 1, 1'b1, 1'b1);
    check_cell("spawn_60", 6, 0, 1'b0, 1'b0);
    check_cell("spawn_42", 4, 2, 1'b0, 1'b0);

    // Wall
    for (int k = 0; k < 4; k++) move_cmd("wall_left", CMD_LEFT, 1'b1);
    move_cmd("wall_5th", CMD_LEFT, 1'b0);
    check_cell("wall_00", 0, 0, 1'b1, 1'b1);
    check_cell("wall_11", 1, 1, 1'b1, 1'b1);
    check_cell("wall_20", 2, 0, 1'b0, 1'b0);
    check_cell("rd_oob_x", 12, 0, 1'b0, 1'b0);

    // Line clear
    hard_drop("lc0");
    wait_play("lc0_play", 60);
    check_cell("lc0_0_19", 0, 19, 1'b1, 1'b0);
    check_cell("lc0_1_18", 1, 18, 1'b1, 1'b0);
    check_cell("lc0_0_17", 0, 17, 1'b0, 1'b0);
    check_cell("lc0_2_19", 2, 19, 1'b0, 1'b0);
    drop_at("lc2", 2);
    drop_at("lc4", 4);
    drop_at("lc6", 6);
    drop_at("lc8", 8);
    wait_play("lc_after", 60);
    check("lc_lines", 32'(lines_cleared), 32'd2);
    count_cells(fixed, act);
    check("lc_fixed", 32'(fixed), 32'd0);
    check("lc_active", 32'(act), 32'd4);

    // Collision: tick and left in the same cycle
    step();
    cmd = CMD_LEFT; cmd_valid = 1'b1; tick = 1'b1;
    step();
    cmd_valid = 1'b0; tick = 1'b0;
    check("col_done", 32'(cmd_done), 32'd1);
    check("col_ok", 32'(cmd_ok), 32'd1);
    check_cell("col_30", 3, 0, 1'b1, 1'b1);
    check_cell("col_50", 5, 0, 1'b0, 1'b0);
    step();
    check_cell("col_30b", 3, 0, 1'b0, 1'b0);
    check_cell("col_32", 3, 2, 1'b1, 1'b1);

    // Game over
    move_cmd("go_right", CMD_RIGHT, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) wait_play("go_play", 60);
      hard_drop("go_drop");
    end
    n = 0;
    while (!game_over && n < 60) begin
      step();
      n++;
    end
    check("go_over", 32'(game_over), 32'd1);
    check("go_ready", 32'(cmd_ready), 32'd0);
    check("go_lines", 32'(lines_cleared), 32'd2);
    check_cell("go_40", 4, 0, 1'b1, 1'b0);
    check_cell("go_5_19", 5, 19, 1'b1, 1'b0);
    check_cell("go_3_10", 3, 10, 1'b0, 1'b0);
    check_cell("rd_oob_y", 4, 25, 1'b0, 1'b0);
    cmd = CMD_LEFT; cmd_valid = 1'b1; tick = 1'b1;
    step(); step();
    cmd_valid = 1'b0; tick = 1'b0;
    check("go_ready2", 32'(cmd_ready), 32'd0);
    check("go_nodone", 32'(cmd_done), 32'd0);
    check("go_sticky", 32'(game_over), 32'd1);

    // Reset during SHIFT
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    wait_play("rs_play", 2);
    check("rs_over", 32'(game_over), 32'd0);
    check("rs_lines0", 32'(lines_cleared), 32'd0);
    drop_at("rs0", 0);
    drop_at("rs2", 2);
    drop_at("rs4", 4);
    drop_at("rs6", 6);
    drop_at("rs8", 8);
    step();          // LOCK -> SCAN
    step();          // SCAN -> SHIFT
    check("rs_preshift", 32'(lines_cleared), 32'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rs_lines", 32'(lines_cleared), 32'd0);
    check("rs_ready0", 32'(cmd_ready), 32'd0);
    wait_play("rs_resume", 2);
    count_cells(fixed, act);
    check("rs_fixed", 32'(fixed), 32'd0);
    check("rs_active", 32'(act), 32'd4);
    check_cell("rs_40", 4, 0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
